// File: rtl/hamming_encode_stream_if.sv
// Stream interface for the Hamming encoder stage.
//   in_valid/in_ready/in_data               : 8-bit data words into the encoder
//   out_valid/out_ready/out_data/out_injected : 12-bit codewords out of the FIFO
// Modports:
//   master : the side that produces data words and consumes codewords
//   slave  : the encoder itself
interface hamming_encode_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_injected;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_injected
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_injected
  );
endinterface

// File: rtl/hamming_encode_stream.sv
// Hamming SEC encoder stage with output FIFO and one-shot error injector.
// Accepted 8-bit words are encoded into 12-bit codewords (parity at r0, r1,
// r3, r7; data in the remaining positions) and queued in a DEPTH-entry FIFO.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   s           : stream interface (slave modport), input words / output codewords
//   inj_arm     : pulse to arm a single-bit flip of the next accepted word
//   inj_pos     : bit position to flip (0..11)
//   inj_armed   : injector holds an unconsumed flip
//   inj_reject  : one-cycle pulse after an arm request with inj_pos > 11
//   fifo_level  : FIFO occupancy
//   word_count  : number of accepted words, saturating
module hamming_encode_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming_encode_stream_if.slave   s,
  input  logic                     inj_arm,
  input  logic [3:0]               inj_pos,
  output logic                     inj_armed,
  output logic                     inj_reject,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

  function automatic logic [11:0] hamming_encode(input logic [7:0] d);
    logic [11:0] r;
    r[2]  = d[0];
    r[4]  = d[1];
    r[5]  = d[2];
    r[6]  = d[3];
    r[8]  = d[4];
    r[9]  = d[5];
    r[10] = d[6];
    r[11] = d[7];
    r[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    r[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    r[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    r[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return r;
  endfunction

  // Control state
  inj_state_e       state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic             reject_q, reject_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;

  // FIFO storage: data only, never reset; empty-state outputs are masked instead
  logic [11:0]      mem_q     [DEPTH];
  logic             inj_mem_q [DEPTH];

  logic             push, pop, flip;
  logic [11:0]      word_d;

  assign s.in_ready  = (level_q < LW'(DEPTH));
  assign s.out_valid = (level_q != '0);
  assign push        = s.in_valid && s.in_ready;
  assign pop         = s.out_valid && s.out_ready;

  // The flip applies to the word accepted while ARMED; an arm request in the
  // same cycle as an IDLE accept only affects the following word.
  assign flip   = push && (state_q == INJ_ARMED);
  assign word_d = hamming_encode(s.in_data) ^ (flip ? (12'b1 << pos_q) : 12'b0);

  assign s.out_data     = s.out_valid ? mem_q[rd_ptr_q]     : 12'b0;
  assign s.out_injected = s.out_valid ? inj_mem_q[rd_ptr_q] : 1'b0;

  assign inj_armed  = (state_q == INJ_ARMED);
  assign inj_reject = reject_q;
  assign fifo_level = level_q;
  assign word_count = count_q;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    reject_d = 1'b0;
    case (state_q)
      INJ_IDLE: begin
        if (inj_arm) begin
          if (inj_pos <= 4'd11) begin
            state_d = INJ_ARMED;
            pos_d   = inj_pos;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      INJ_ARMED: begin
        if (push) state_d = INJ_IDLE;
      end
      default: state_d = INJ_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INJ_IDLE;
      pos_q    <= 4'd0;
      reject_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      reject_q <= reject_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
    end
  end

  // Encode/inject stage -> FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]     <= word_d;
      inj_mem_q[wr_ptr_q] <= flip;
    end
  end

endmodule

// File: tb/tb_hamming_encode_stream.sv
// Self-checking bench for hamming_encode_stream. A queue-based model tracks
// the FIFO, the injector and the counter; codewords come from a generic
// position-based Hamming construction (parity at power-of-two positions).
module tb_hamming_encode_stream;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic inj_arm;
  logic [3:0] inj_pos;
  logic inj_armed, inj_reject;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0] word_count;

  logic sat_inj_armed, sat_inj_reject;
  logic [$clog2(DEPTH):0] sat_level;
  logic [3:0] sat_count;

  hamming_encode_stream_if bus ();
  hamming_encode_stream_if sat_bus ();

  hamming_encode_stream #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s(bus),
    .inj_arm(inj_arm), .inj_pos(inj_pos),
    .inj_armed(inj_armed), .inj_reject(inj_reject),
    .fifo_level(fifo_level), .word_count(word_count)
  );

  // Narrow-counter instance for the saturation check
  hamming_encode_stream #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .s(sat_bus),
    .inj_arm(1'b0), .inj_pos(4'd0),
    .inj_armed(sat_inj_armed), .inj_reject(sat_inj_reject),
    .fifo_level(sat_level), .word_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [12:0] mq[$];   // {injected, codeword}
  int  m_count = 0;
  bit  m_armed = 0;
  int  m_pos   = 0;
  bit  m_reject = 0;
  bit  acc;

  function automatic logic [11:0] model_code(input logic [7:0] d);
    logic [11:0] r;
    logic par;
    int k;
    r = '0;
    k = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        r[p-1] = d[k];
        k++;
      end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p & (p - 1)) != 0) && (((p >> b) & 1) == 1)) par = par ^ r[p-1];
      r[(1 << b) - 1] = par;
    end
    return r;
  endfunction

  function automatic logic [11:0] head_code();
    return (mq.size() > 0) ? mq[0][11:0] : 12'h000;
  endfunction

  function automatic logic head_inj();
    return (mq.size() > 0) ? mq[0][12] : 1'b0;
  endfunction

  // Advance one clock and update the model with pre-edge inputs.
  task automatic tick(output bit accepted);
    bit push, pop, n_armed, n_rej;
    int n_pos;
    logic [12:0] item;
    push = bus.in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && bus.out_ready;
    item = {1'b0, model_code(bus.in_data)};
    if (m_armed) item = {1'b1, item[11:0] ^ (12'd1 << m_pos)};
    n_armed = m_armed;
    n_pos   = m_pos;
    n_rej   = 1'b0;
    if (!m_armed) begin
      if (inj_arm) begin
        if (inj_pos <= 4'd11) begin
          n_armed = 1'b1;
          n_pos   = int'(inj_pos);
        end else begin
          n_rej = 1'b1;
        end
      end
    end else if (push) begin
      n_armed = 1'b0;
    end
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(item);
      if (m_count < 65535) m_count++;
    end
    m_armed  = n_armed;
    m_pos    = n_pos;
    m_reject = n_rej;
    accepted = push;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    inj_arm       = 1'b0;
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) tick(acc);
    tick(acc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    sat_bus.in_valid = 1'b0; sat_bus.in_data = 8'h00; sat_bus.out_ready = 1'b0;
    inj_arm = 1'b0; inj_pos = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 12'h000) begin errors++; $display("FAIL rst_out_data got %h exp 000", bus.out_data); end
    checks++; if (bus.out_injected !== 1'b0) begin errors++; $display("FAIL rst_out_injected got %0b exp 0", bus.out_injected); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (inj_armed !== 1'b0) begin errors++; $display("FAIL rst_inj_armed got %0b exp 0", inj_armed); end
    checks++; if (inj_reject !== 1'b0) begin errors++; $display("FAIL rst_inj_reject got %0b exp 0", inj_reject); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_fifo_level got %0d exp 0", fifo_level); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count got %0d exp 0", word_count); end
    rst = 1'b0;
    tick(acc);
  endtask

  task automatic test_encode();
    logic [7:0]  words [4];
    logic [11:0] exp   [4];
    words = '{8'h00, 8'h01, 8'hFF, 8'hA5};
    exp   = '{12'h000, 12'h007, 12'hF77, 12'hA27};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      tick(acc);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d] got %0b exp 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== exp[i]) begin errors++; $display("FAIL enc_data[%0d] got %h exp %h", i, bus.out_data, exp[i]); end
      checks++; if (bus.out_injected !== 1'b0) begin errors++; $display("FAIL enc_inj[%0d] got %0b exp 0", i, bus.out_injected); end
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
      checks++; if (bus.in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready c%0d got %0b exp %0b", c, bus.in_ready, mq.size() < DEPTH); end
      checks++; if (bus.out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_out_valid c%0d got %0b exp %0b", c, bus.out_valid, mq.size() > 0); end
      checks++; if (bus.out_data !== head_code()) begin errors++; $display("FAIL rnd_out_data c%0d got %h exp %h", c, bus.out_data, head_code()); end
      checks++; if (bus.out_injected !== head_inj()) begin errors++; $display("FAIL rnd_out_inj c%0d got %0b exp %0b", c, bus.out_injected, head_inj()); end
      checks++; if (int'(fifo_level) != mq.size()) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", c, fifo_level, mq.size()); end
      checks++; if (int'(word_count) != m_count) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, word_count, m_count); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] bp [5];
    int n_pop;
    for (int i = 0; i < 5; i++) bp[i] = 8'($urandom);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = bp[i];
      tick(acc);
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_full_level got %0d exp 4", fifo_level); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", bus.in_ready); end
    bus.in_data = bp[4];
    tick(acc);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_held_level got %0d exp 4", fifo_level); end
    checks++; if (int'(word_count) != m_count) begin errors++; $display("FAIL bp_held_count got %0d exp %0d", word_count, m_count); end
    bus.out_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 20 && n_pop < 5; c++) begin
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_data !== model_code(bp[n_pop])) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", n_pop, bus.out_data, model_code(bp[n_pop])); end
        n_pop++;
      end
      tick(acc);
      if (acc) bus.in_valid = 1'b0;
    end
    checks++; if (n_pop != 5) begin errors++; $display("FAIL bp_drain_timeout got %0d exp 5", n_pop); end
    drain();
  endtask

  task automatic test_injection();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    inj_arm = 1'b1; inj_pos = 4'd5;
    tick(acc);
    inj_arm = 1'b0;
    checks++; if (inj_armed !== 1'b1) begin errors++; $display("FAIL inj_armed_set got %0b exp 1", inj_armed); end
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    tick(acc);
    checks++; if (bus.out_data !== 12'hA07) begin errors++; $display("FAIL inj_data got %h exp a07", bus.out_data); end
    checks++; if (bus.out_injected !== 1'b1) begin errors++; $display("FAIL inj_flag got %0b exp 1", bus.out_injected); end
    checks++; if (inj_armed !== 1'b0) begin errors++; $display("FAIL inj_armed_clr got %0b exp 0", inj_armed); end
    tick(acc);
    checks++; if (bus.out_data !== 12'hA27) begin errors++; $display("FAIL inj_next_data got %h exp a27", bus.out_data); end
    checks++; if (bus.out_injected !== 1'b0) begin errors++; $display("FAIL inj_next_flag got %0b exp 0", bus.out_injected); end
    bus.in_valid = 1'b0;
    drain();
    // Arm while armed is ignored; arm during an IDLE accept applies to the next word
    inj_arm = 1'b1; inj_pos = 4'd3;
    tick(acc);
    inj_pos = 4'd7;
    tick(acc);
    inj_arm = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h00;
    tick(acc);
    checks++; if (bus.out_data !== 12'h008) begin errors++; $display("FAIL inj_rearm_data got %h exp 008", bus.out_data); end
    inj_arm = 1'b1; inj_pos = 4'd0;
    tick(acc);
    inj_arm = 1'b0;
    checks++; if (bus.out_data !== 12'h000 || bus.out_injected !== 1'b0) begin errors++; $display("FAIL inj_same_cycle got %h/%0b exp 000/0", bus.out_data, bus.out_injected); end
    checks++; if (inj_armed !== 1'b1) begin errors++; $display("FAIL inj_same_cycle_armed got %0b exp 1", inj_armed); end
    tick(acc);
    checks++; if (bus.out_data !== 12'h001 || bus.out_injected !== 1'b1) begin errors++; $display("FAIL inj_following got %h/%0b exp 001/1", bus.out_data, bus.out_injected); end
    checks++; if (bus.out_data !== head_code()) begin errors++; $display("FAIL inj_model got %h exp %h", bus.out_data, head_code()); end
    drain();
  endtask

  task automatic test_reject();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    inj_arm = 1'b1; inj_pos = 4'd12;
    tick(acc);
    inj_arm = 1'b0;
    checks++; if (inj_reject !== 1'b1) begin errors++; $display("FAIL rej_pulse got %0b exp 1", inj_reject); end
    checks++; if (inj_armed !== 1'b0) begin errors++; $display("FAIL rej_armed got %0b exp 0", inj_armed); end
    bus.in_valid = 1'b1; bus.in_data = 8'h01;
    tick(acc);
    checks++; if (inj_reject !== m_reject) begin errors++; $display("FAIL rej_end got %0b exp %0b", inj_reject, m_reject); end
    checks++; if (bus.out_data !== 12'h007 || bus.out_injected !== 1'b0) begin errors++; $display("FAIL rej_data got %h/%0b exp 007/0", bus.out_data, bus.out_injected); end
    drain();
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_data = 8'($urandom);
      tick(acc);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'($urandom);
      tick(acc);
      checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL sim_level[%0d] got %0d exp 2", i, fifo_level); end
      checks++; if (bus.out_data !== head_code()) begin errors++; $display("FAIL sim_order[%0d] got %h exp %h", i, bus.out_data, head_code()); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'($urandom);
      tick(acc);
    end
    bus.in_valid = 1'b0;
    inj_arm = 1'b1; inj_pos = 4'd2;
    tick(acc);
    inj_arm = 1'b0;
    checks++; if (fifo_level !== 3'd3 || inj_armed !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0d/%0b exp 3/1", fifo_level, inj_armed); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", bus.out_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rstmid_level got %0d exp 0", fifo_level); end
    checks++; if (inj_armed !== 1'b0) begin errors++; $display("FAIL rstmid_armed got %0b exp 0", inj_armed); end
    checks++; if (bus.out_data !== 12'h000 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_outs got %h/%0b exp 000/1", bus.out_data, bus.in_ready); end
    mq.delete();
    m_armed = 0; m_count = 0; m_reject = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h01;
    tick(acc);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_data !== 12'h007 || bus.out_injected !== 1'b0) begin errors++; $display("FAIL rstmid_after got %h/%0b exp 007/0", bus.out_data, bus.out_injected); end
    drain();
  endtask

  task automatic test_saturation();
    sat_bus.out_ready = 1'b1;
    sat_bus.in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sat_bus.in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    checks++; if (sat_count !== 4'd14) begin errors++; $display("FAIL sat_mid got %0d exp 14", sat_count); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (sat_count !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d exp 15", sat_count); end
    sat_bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_random();
    test_backpressure();
    test_injection();
    test_reject();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
